// File: rtl/mcpu_mem_dump.sv
// Read-back engine for the MCPU 256-word RAM: streams {addr, word} for an inclusive
// address window through a 2-entry skid FIFO on a valid/ready output.
module mcpu_mem_dump #(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 16,
  parameter int unsigned FifoDepth = 2
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] start_addr_i,
  input  logic [AddrWidth-1:0] end_addr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 mem_rd_en_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  input  logic [DataWidth-1:0] mem_rd_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [AddrWidth-1:0] out_addr_o,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_last_o
);

  localparam int unsigned IdxW = $clog2(FifoDepth);
  localparam int unsigned CntW = IdxW + 1;
  localparam int unsigned RemW = AddrWidth + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
    logic                 last;
  } entry_t;

  state_e               state_q;
  logic                 busy_q, done_q;
  logic [AddrWidth-1:0] rd_ptr_q;
  logic [RemW-1:0]      remaining_q;
  logic [AddrWidth-1:0] mem_addr_q;
  logic                 inflight_q;
  logic [AddrWidth-1:0] inflight_addr_q;
  logic                 inflight_last_q;
  entry_t               fifo_q [FifoDepth];
  logic [IdxW-1:0]      wr_idx_q, rd_idx_q;
  logic [CntW-1:0]      count_q;

  logic                 issue, push, pop;
  logic [CntW:0]        credit;
  entry_t               head;

  always_comb begin
    head        = fifo_q[rd_idx_q];
    out_valid_o = (count_q != '0);
    out_addr_o  = head.addr;
    out_data_o  = head.data;
    out_last_o  = head.last;
    pop         = out_valid_o && out_ready_i;
    push        = inflight_q;
    // Words still owed to the consumer after this cycle's pop; a pop frees a slot at once,
    // which is what lets the stream sustain one word per clock.
    credit      = {1'b0, count_q} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
    issue       = (state_q == StRun) && (remaining_q != '0) &&
                  (credit < (CntW + 1)'(FifoDepth));
    mem_rd_en_o = issue;
    mem_addr_o  = issue ? rd_ptr_q : mem_addr_q;
    busy_o      = busy_q;
    done_o      = done_q;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q         <= StIdle;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      rd_ptr_q        <= '0;
      remaining_q     <= '0;
      mem_addr_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      inflight_last_q <= 1'b0;
      wr_idx_q        <= '0;
      rd_idx_q        <= '0;
      count_q         <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      inflight_q <= issue;
      if (issue) begin
        rd_ptr_q        <= rd_ptr_q + 1'b1;
        remaining_q     <= remaining_q - 1'b1;
        mem_addr_q      <= rd_ptr_q;
        inflight_addr_q <= rd_ptr_q;
        inflight_last_q <= (remaining_q == RemW'(1));
      end
      if (push) begin
        fifo_q[wr_idx_q] <= '{addr: inflight_addr_q, data: mem_rd_data_i, last: inflight_last_q};
        wr_idx_q         <= wr_idx_q + 1'b1;
      end
      if (pop) begin
        rd_idx_q <= rd_idx_q + 1'b1;
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
      done_q  <= 1'b0;

      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q     <= StRun;
            busy_q      <= 1'b1;
            rd_ptr_q    <= start_addr_i;
            remaining_q <= {1'b0, end_addr_i - start_addr_i} + RemW'(1);
          end
        end
        StRun: begin
          if (issue && (remaining_q == RemW'(1))) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && head.last) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_mem_dump.sv
// Self-checking bench for mcpu_mem_dump: behavioural synchronous RAM, scoreboard of
// expected {addr, data, last} filled at each start, checked at every output handshake.
module tb_mcpu_mem_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  start_addr, end_addr;
  logic        busy, done, mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rd_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_addr;
  logic [15:0] out_data;
  logic        out_last;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic [15:0] mem [256];
  exp_t        exp_q [$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          got_cnt = 0;
  int          outstanding = 0;
  int          ready_mode = 0;
  bit          mon_en = 1'b0;
  bit          done_seen = 1'b0;
  bit          hs_last_pend = 1'b0;
  bit          stall_prev = 1'b0;
  logic        hs_now;
  logic [7:0]  st_addr;
  logic [15:0] st_data;
  logic        st_last;

  always #5 clk = ~clk;

  mcpu_mem_dump dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .start_i      (start),
    .start_addr_i (start_addr),
    .end_addr_i   (end_addr),
    .busy_o       (busy),
    .done_o       (done),
    .mem_rd_en_o  (mem_rd_en),
    .mem_addr_o   (mem_addr),
    .mem_rd_data_i(mem_rd_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_addr_o   (out_addr),
    .out_data_o   (out_data),
    .out_last_o   (out_last)
  );

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Consumer ready pattern, changed just after each active edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      stall_prev   = 1'b0;
      hs_last_pend = 1'b0;
      outstanding  = 0;
    end else begin
      hs_now = out_valid && out_ready;
      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_addr", out_addr, st_addr);
        check("stall_data", out_data, st_data);
        check("stall_last", out_last, st_last);
      end
      if (hs_last_pend) begin
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        if (done) done_seen = 1'b1;
        hs_last_pend = 1'b0;
      end else if (done) begin
        check("done_unexpected", done, 0);
      end
      if (hs_now) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_addr", out_addr, e.addr);
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
          got_cnt++;
        end
        if (out_last) hs_last_pend = 1'b1;
      end
      if (mem_rd_en) outstanding++;
      if (hs_now) outstanding--;
      if (mem_rd_en) check("outstanding_le2", outstanding <= 2, 1);
      stall_prev = out_valid && !out_ready;
      st_addr    = out_addr;
      st_data    = out_data;
      st_last    = out_last;
    end
  end

  task automatic reset_outputs_check();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
  endtask

  task automatic run_dump(input logic [7:0] s, input logic [7:0] en, input bit lat,
                          input bit restart);
    int         n;
    int         guard;
    logic [7:0] a;
    logic [7:0] span;
    span = en - s;
    n = int'(span) + 1;
    for (int i = 0; i < n; i++) begin
      a = s + 8'(i);
      exp_q.push_back('{addr: a, data: mem[a], last: (i == n - 1)});
    end
    got_cnt   = 0;
    done_seen = 1'b0;
    @(negedge clk);
    start      = 1'b1;
    start_addr = s;
    end_addr   = en;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (lat) begin
      check("valid_edge1", out_valid, 0);
      @(negedge clk);
      check("valid_edge2", out_valid, 0);
      @(negedge clk);
      check("valid_edge3", out_valid, 1);
    end
    if (restart) begin
      repeat (2) @(negedge clk);
      start      = 1'b1;
      start_addr = 8'd100;
      end_addr   = 8'd120;
      @(negedge clk);
      start = 1'b0;
    end
    guard = 0;
    while (!done_seen && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", done_seen, 1);
    check("word_count", got_cnt, n);
    check("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    end_addr   = '0;
    repeat (3) @(negedge clk);
    reset_outputs_check();
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Basic window with latency check, then stalled variants.
    ready_mode = 0;
    run_dump(8'd0, 8'd9, 1'b1, 1'b0);
    ready_mode = 1;
    run_dump(8'd0, 8'd9, 1'b0, 1'b0);
    ready_mode = 2;
    run_dump(8'd20, 8'd60, 1'b0, 1'b0);

    // Wrap-around and single-word windows.
    ready_mode = 0;
    run_dump(8'd254, 8'd1, 1'b0, 1'b0);
    run_dump(8'd7, 8'd7, 1'b0, 1'b0);

    // Full dump of a post-Hailstone memory image.
    mem[0] = 16'h1004; mem[1] = 16'h2118; mem[2] = 16'h3001; mem[3] = 16'h4012;
    mem[4] = 16'h5230; mem[5] = 16'h6201; mem[6] = 16'h7003; mem[7] = 16'h8110;
    mem[8] = 16'h9004; mem[9] = 16'hF000;
    x = 32'd4488;
    for (int i = 10; i < 256; i++) begin
      mem[i] = x[15:0];
      if (x == 32'd1) x = 32'd1;
      else if (x[0] == 1'b0) x = x >> 1;
      else x = 3 * x + 1;
    end
    ready_mode = 2;
    run_dump(8'd0, 8'd255, 1'b0, 1'b0);

    // Reset while words are buffered mid-dump.
    ready_mode = 3;
    repeat (2) @(negedge clk);
    start      = 1'b1;
    start_addr = 8'd30;
    end_addr   = 8'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("buffered_valid", out_valid, 1);
    mon_en = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    reset_outputs_check();
    rst = 1'b0;
    @(negedge clk);
    check("no_done_after_rst", done, 0);
    exp_q.delete();
    ready_mode = 0;
    @(negedge clk);
    mon_en = 1'b1;
    run_dump(8'd5, 8'd8, 1'b0, 1'b0);

    // Start re-pulsed while busy must be ignored.
    ready_mode = 2;
    run_dump(8'd0, 8'd9, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("final_idle_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
